// File: rtl/pixel_pkg.sv
// Shared constants for the pixel filter: pixel width, kernel mode encodings, smooth-sum width.
package pixel_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned SUM_W = 10;

  localparam logic [PIX_W-1:0] PIX_MAX = 8'd255;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_INV    = 2'b01;
  localparam logic [1:0] MODE_THR    = 2'b10;
  localparam logic [1:0] MODE_SMOOTH = 2'b11;

endpackage

// File: rtl/pixel_filter_row_tap3.sv
// Row tap registers (x-1, x-2) with edge replication at row start, plus the 1-2-1 smooth kernel.
module row_tap3
  import pixel_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic             row_start,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] smooth_c
);

  logic [PIX_W-1:0] p1_q, p1_d;
  logic [PIX_W-1:0] p2_q, p2_d;
  logic [PIX_W-1:0] p1_c, p2_c;
  logic [SUM_W-1:0] sum_c;

  // At row start both taps replicate the current pixel; shifting that value into p2
  // also makes x==1 see p2==p1 without a separate case.
  always_comb begin
    p1_c = row_start ? pix_in : p1_q;
    p2_c = row_start ? pix_in : p2_q;
    p1_d = p1_q;
    p2_d = p2_q;
    if (pix_valid) begin
      p1_d = pix_in;
      p2_d = p1_c;
    end
    sum_c    = SUM_W'(p2_c) + (SUM_W'(p1_c) << 1) + SUM_W'(pix_in);
    smooth_c = sum_c[SUM_W-1:2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_q <= '0;
      p2_q <= '0;
    end else begin
      p1_q <= p1_d;
      p2_q <= p2_d;
    end
  end

endmodule

// File: rtl/pixel_filter.sv
// Per-pixel filter between RX drain and TX FIFO: point/3-tap kernels, position tracking,
// one-entry hold buffer for TX backpressure. Optional checksum port: PIXEL_FILTER_CHECKSUM_EN.
module pixel_filter
  import pixel_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [PIX_W-1:0] w_data,
  output logic             frame_done,
  output logic             overflow,
  output logic             busy
`ifdef PIXEL_FILTER_CHECKSUM_EN
  ,
  output logic [15:0]      checksum
`endif
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [1:0]       mode_q, mode_d;
  logic             hold_vld_q, hold_vld_d;
  logic [PIX_W-1:0] hold_q, hold_d;
  logic             wr_q, wr_d;
  logic [PIX_W-1:0] wdata_q, wdata_d;
  logic             fd_q, fd_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  logic             frame_start_c;
  logic             row_start_c;
  logic [1:0]       eff_mode_c;
  logic [PIX_W-1:0] smooth_c;
  logic [PIX_W-1:0] kernel_c;

  row_tap3 u_tap (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .row_start (row_start_c),
    .pix_in    (pix_in),
    .smooth_c  (smooth_c)
  );

  // Kernel select; the first pixel of a frame uses the live mode it is latching.
  always_comb begin
    frame_start_c = (x_q == '0) && (y_q == '0);
    row_start_c   = (x_q == '0);
    eff_mode_c    = frame_start_c ? mode : mode_q;
    kernel_c      = pix_in;
    case (eff_mode_c)
      MODE_PASS:   kernel_c = pix_in;
      MODE_INV:    kernel_c = PIX_MAX - pix_in;
      MODE_THR:    kernel_c = (pix_in >= thresh) ? PIX_MAX : '0;
      MODE_SMOOTH: kernel_c = smooth_c;
      default:     kernel_c = pix_in;
    endcase
  end

  // Position counters, mode latch, hold buffer and TX handshake.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    mode_d     = mode_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;
    fd_d       = 1'b0;
    ovf_d      = ovf_q;

    if (pix_valid) begin
      if (frame_start_c) begin
        mode_d = mode;
      end
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          fd_d = 1'b1;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    // The held pixel always drains before a new one; a new one behind a stuck hold is lost.
    if (hold_vld_q) begin
      if (!tx_full) begin
        wr_d       = 1'b1;
        wdata_d    = hold_q;
        hold_vld_d = pix_valid;
        if (pix_valid) begin
          hold_d = kernel_c;
        end
      end else if (pix_valid) begin
        ovf_d = 1'b1;
      end
    end else if (pix_valid) begin
      if (!tx_full) begin
        wr_d    = 1'b1;
        wdata_d = kernel_c;
      end else begin
        hold_vld_d = 1'b1;
        hold_d     = kernel_c;
      end
    end

    busy_d = (x_d != '0) || (y_d != '0) || hold_vld_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      mode_q     <= MODE_PASS;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      fd_q       <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      mode_q     <= mode_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      fd_q       <= fd_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_uart    = wr_q;
  assign w_data     = wdata_q;
  assign frame_done = fd_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;

`ifdef PIXEL_FILTER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // Running sum of every kernel result, restarted on the first pixel of each frame.
  always_comb begin
    csum_d = csum_q;
    if (pix_valid) begin
      csum_d = frame_start_c ? 16'(kernel_c) : csum_q + 16'(kernel_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_pixel_filter.sv
// Directed bench for pixel_filter (IMG_W=4, IMG_H=2): kernel vector table plus
// backpressure, overflow and mid-frame reset sequences.
module tb_pixel_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_valid;
  logic [7:0] pix_in;
  logic [1:0] mode;
  logic [7:0] thresh;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       frame_done;
  logic       overflow;
  logic       busy;
`ifdef PIXEL_FILTER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pixel_filter #(.IMG_W(4), .IMG_H(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .mode       (mode),
    .thresh     (thresh),
    .tx_full    (tx_full),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
`ifdef PIXEL_FILTER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  typedef struct {
    logic [1:0] mode;
    logic [7:0] thresh;
    logic [7:0] pix;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One-cycle pulse; returns at the next falling edge where the registered result is visible.
  task automatic send(input logic [7:0] p, input logic tf);
    @(negedge clk);
    pix_in    = p;
    tx_full   = tf;
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_in = '0; mode = 2'b00; thresh = 8'd128; tx_full = 1'b0;

    // Frame A: pass-through
    vecs[0]  = '{2'b00, 8'd0, 8'd10, 8'd10};   vecs[1]  = '{2'b00, 8'd0, 8'd20, 8'd20};
    vecs[2]  = '{2'b00, 8'd0, 8'd30, 8'd30};   vecs[3]  = '{2'b00, 8'd0, 8'd40, 8'd40};
    vecs[4]  = '{2'b00, 8'd0, 8'd50, 8'd50};   vecs[5]  = '{2'b00, 8'd0, 8'd60, 8'd60};
    vecs[6]  = '{2'b00, 8'd0, 8'd70, 8'd70};   vecs[7]  = '{2'b00, 8'd0, 8'd80, 8'd80};
    // Frame B: invert, mode input changes mid-frame but latch holds
    vecs[8]  = '{2'b01, 8'd0, 8'h00, 8'hFF};   vecs[9]  = '{2'b01, 8'd0, 8'hFF, 8'h00};
    vecs[10] = '{2'b10, 8'd0, 8'd5,  8'd250};  vecs[11] = '{2'b11, 8'd0, 8'd100, 8'd155};
    vecs[12] = '{2'b00, 8'd0, 8'd1,  8'd254};  vecs[13] = '{2'b10, 8'd0, 8'd128, 8'd127};
    vecs[14] = '{2'b11, 8'd0, 8'd200, 8'd55};  vecs[15] = '{2'b00, 8'd0, 8'd254, 8'd1};
    // Frame C: threshold, level read live
    vecs[16] = '{2'b10, 8'd128, 8'd127, 8'd0};   vecs[17] = '{2'b10, 8'd128, 8'd128, 8'd255};
    vecs[18] = '{2'b10, 8'd128, 8'd0,   8'd0};   vecs[19] = '{2'b10, 8'd128, 8'd255, 8'd255};
    vecs[20] = '{2'b10, 8'd50,  8'd49,  8'd0};   vecs[21] = '{2'b10, 8'd50,  8'd50,  8'd255};
    vecs[22] = '{2'b10, 8'd50,  8'd200, 8'd255}; vecs[23] = '{2'b10, 8'd50,  8'd10,  8'd0};
    // Frame D: 3-tap smooth with row-start replication
    vecs[24] = '{2'b11, 8'd0, 8'd100, 8'd100}; vecs[25] = '{2'b11, 8'd0, 8'd100, 8'd100};
    vecs[26] = '{2'b11, 8'd0, 8'd200, 8'd125}; vecs[27] = '{2'b11, 8'd0, 8'd0,   8'd125};
    vecs[28] = '{2'b11, 8'd0, 8'd40,  8'd40};  vecs[29] = '{2'b11, 8'd0, 8'd40,  8'd40};
    vecs[30] = '{2'b11, 8'd0, 8'd80,  8'd50};  vecs[31] = '{2'b11, 8'd0, 8'd0,   8'd50};

    repeat (2) @(negedge clk);
    chk("reset_wr_uart", 32'(wr_uart), 0);
    chk("reset_w_data", 32'(w_data), 0);
    chk("reset_frame_done", 32'(frame_done), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 32; i++) begin
      mode   = vecs[i].mode;
      thresh = vecs[i].thresh;
      send(vecs[i].pix, 1'b0);
      chk($sformatf("vec%0d_wr_uart", i), 32'(wr_uart), 1);
      chk($sformatf("vec%0d_w_data", i), 32'(w_data), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_frame_done", i), 32'(frame_done), (i % 8 == 7) ? 1 : 0);
      chk($sformatf("vec%0d_busy", i), 32'(busy), (i % 8 == 7) ? 0 : 1);
`ifdef PIXEL_FILTER_CHECKSUM_EN
      if (i == 7) chk("checksum_frame_a", 32'(checksum), 360);
`endif
    end
    chk("overflow_after_table", 32'(overflow), 0);

    // Stall around a single result: written exactly once when released
    mode = 2'b00;
    send(8'd77, 1'b1);
    chk("stall_wr0", 32'(wr_uart), 0);
    chk("stall_busy", 32'(busy), 1);
    @(negedge clk); chk("stall_wr1", 32'(wr_uart), 0);
    @(negedge clk); chk("stall_wr2", 32'(wr_uart), 0);
    tx_full = 1'b0;
    @(negedge clk);
    chk("release_wr", 32'(wr_uart), 1);
    chk("release_data", 32'(w_data), 77);
    @(negedge clk);
    chk("release_once", 32'(wr_uart), 0);
    chk("stall_no_overflow", 32'(overflow), 0);

    // Hold full and still blocked: second result dropped
    send(8'd11, 1'b1);
    chk("hold_b_wr", 32'(wr_uart), 0);
    send(8'd22, 1'b1);
    chk("drop_c_wr", 32'(wr_uart), 0);
    chk("drop_overflow", 32'(overflow), 1);
    tx_full = 1'b0;
    @(negedge clk);
    chk("drain_b_wr", 32'(wr_uart), 1);
    chk("drain_b_data", 32'(w_data), 11);
    @(negedge clk);
    chk("drain_only_b", 32'(wr_uart), 0);
    chk("overflow_sticky", 32'(overflow), 1);

    // Hold full, new result arrives as TX frees: hold written, new one queued behind it
    send(8'd33, 1'b1);
    chk("hold_d_wr", 32'(wr_uart), 0);
    send(8'd44, 1'b0);
    chk("swap_wr_d", 32'(wr_uart), 1);
    chk("swap_data_d", 32'(w_data), 33);
    @(negedge clk);
    chk("swap_wr_e", 32'(wr_uart), 1);
    chk("swap_data_e", 32'(w_data), 44);
    @(negedge clk);
    chk("swap_idle", 32'(wr_uart), 0);

    // Reset at x==2 of row 1, then a fresh frame in a new mode
    send(8'd99, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_wr_uart", 32'(wr_uart), 0);
    chk("midreset_w_data", 32'(w_data), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_overflow", 32'(overflow), 0);
    reset = 1'b0;
    mode  = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      send(8'(10 * i), 1'b0);
      mode = 2'b00;
      chk($sformatf("post_reset%0d_data", i), 32'(w_data), 32'(255 - 10 * i));
      chk($sformatf("post_reset%0d_frame_done", i), 32'(frame_done), (i == 7) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
